// File: rtl/video_timing_gen.sv
// Raster timing generator: sync pulses, data enable, pixel coordinates, line/frame strobes and early fetch request.
// Define VIDEO_TIMING_TEST_PATTERN_EN to add the 12-bit colour-bar output rgb.
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CNT_WIDTH = 10,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic                 clock_in,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 active,
   output logic [CNT_WIDTH-1:0] pos_x,
   output logic [CNT_WIDTH-1:0] pos_y,
   output logic                 line_start,
   output logic                 frame_start,
   output logic                 fetch_req
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
   ,
   output logic [11:0]          rgb
`endif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
   localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);

   logic [CNT_WIDTH-1:0] next_x;
   logic [CNT_WIDTH-1:0] next_y;
   logic [CNT_WIDTH-1:0] after_x;
   logic [CNT_WIDTH-1:0] after_y;
   logic                 next_active;
   logic                 next_hsync_on;
   logic                 next_vsync_on;

   function automatic logic in_visible(input logic [CNT_WIDTH-1:0] x,
                                       input logic [CNT_WIDTH-1:0] y);
      return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
   endfunction

   // Decode the position about to be entered (next) and the one after it (after),
   // so every registered output lines up with the coordinates it is shown with.
   always_comb begin
      next_x  = (pos_x == H_LAST) ? '0 : pos_x + 1'b1;
      next_y  = pos_y;
      if (pos_x == H_LAST) begin
         next_y = (pos_y == V_LAST) ? '0 : pos_y + 1'b1;
      end
      after_x = (next_x == H_LAST) ? '0 : next_x + 1'b1;
      after_y = next_y;
      if (next_x == H_LAST) begin
         after_y = (next_y == V_LAST) ? '0 : next_y + 1'b1;
      end
      next_active   = in_visible(next_x, next_y);
      next_hsync_on = (int'(next_x) >= HS_START) && (int'(next_x) < HS_END);
      next_vsync_on = (int'(next_y) >= VS_START) && (int'(next_y) < VS_END);
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         pos_x       <= H_LAST;
         pos_y       <= V_LAST;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         fetch_req   <= 1'b0;
      end else if (enable) begin
         pos_x       <= next_x;
         pos_y       <= next_y;
         hsync       <= next_hsync_on ? SYNC_POL : ~SYNC_POL;
         vsync       <= next_vsync_on ? SYNC_POL : ~SYNC_POL;
         active      <= next_active;
         line_start  <= (next_x == '0);
         frame_start <= (next_x == '0) && (next_y == '0);
         fetch_req   <= in_visible(after_x, after_y);
      end
   end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
   logic [11:0] next_rgb;

   // Eight equal-width bars across the visible width; black outside the visible area.
   always_comb begin
      next_rgb = 12'h000;
      if (next_active) begin
         case (int'(next_x) / BAR_W)
            0:       next_rgb = 12'hFFF;
            1:       next_rgb = 12'hFF0;
            2:       next_rgb = 12'h0FF;
            3:       next_rgb = 12'h0F0;
            4:       next_rgb = 12'hF0F;
            5:       next_rgb = 12'hF00;
            6:       next_rgb = 12'h00F;
            default: next_rgb = 12'h000;
         endcase
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         rgb <= 12'h000;
      end else if (enable) begin
         rgb <= next_rgb;
      end
   end
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator clocked by the 24 MHz pixel clock from the on-board PLL. Produces hsync/vsync, active-video (data enable), pixel coordinates and frame/line strobes. Also issues a one-cycle-early fetch request so the downstream framebuffer reader can deliver pixel data aligned with active video.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CNT_WIDTH, 10, width of the pos_x and pos_y counters; must hold H_TOTAL-1 and V_TOTAL-1
SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high

Ports:
clock_in  input  1  pixel clock, 24 MHz PLL output
reset  input  1  synchronous, active-high
enable  input  1  advance the raster by one pixel per cycle when high
hsync  output  1  horizontal sync, polarity per SYNC_POL
vsync  output  1  vertical sync, polarity per SYNC_POL
active  output  1  current pixel is inside the visible area
pos_x  output  CNT_WIDTH  current pixel column
pos_y  output  CNT_WIDTH  current line
line_start  output  1  one-cycle pulse when pos_x==0
frame_start  output  1  one-cycle pulse when pos_x==0 and pos_y==0
fetch_req  output  1  next enabled cycle will be an active pixel
rgb  output  12  4:4:4 test-pattern colour; exists only with the optional feature

Behaviour:
- Clock and reset: single clock domain, clock_in. Reset is synchronous and active-high. All outputs are registered. No combinational path from any input to any output.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
  - Frame length at defaults = 420000 cycles.
- Reset:
  - pos_x = H_TOTAL-1, pos_y = V_TOTAL-1.
  - hsync and vsync at their inactive level.
  - active, line_start, frame_start, fetch_req, rgb = 0.
- Counting: on each cycle with enable=1:
  - pos_x increments.
  - At H_TOTAL-1, pos_x wraps to 0 and pos_y increments.
  - pos_y wraps from V_TOTAL-1 to 0.
  - The first enabled cycle after reset therefore lands on (0,0), with frame_start=1, line_start=1 and active=1.
- enable=0: counters and every output hold their value. Strobes hold too, so a pulse persists until the next enabled cycle.
- Output alignment: every output describes the (pos_x, pos_y) it is presented with in the same cycle. The implementation computes next-position decode before the register.
- active = (pos_x < H_ACTIVE) && (pos_y < V_ACTIVE).
- hsync is asserted for H_ACTIVE+H_FP <= pos_x < H_ACTIVE+H_FP+H_SYNC. At defaults this is x = 656..751.
- vsync is asserted for V_ACTIVE+V_FP <= pos_y < V_ACTIVE+V_FP+V_SYNC (lines 490..491 at defaults). vsync changes only together with pos_x wrapping to 0.
- fetch_req = 1 exactly when the position reached on the next enabled cycle is active. It therefore leads active by one enabled cycle, including across line and frame wrap. Timing at defaults:
  - Goes high at (799, y-1) for each visible line y >= 1.
  - Goes high at (799, 524) for line 0.
  - Goes low at (639, y).
- Reset mid-frame: the block returns to the reset state on the next edge, regardless of position or enable. There is no partial pulse; a sync pulse in progress ends immediately.
- Simultaneous reset and enable: reset wins.

Optional Feature:
- Macro: VIDEO_TIMING_TEST_PATTERN_EN.
- Defined: adds the rgb port. rgb shows 8 vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Values at full 4-bit intensity, e.g. white = 12'hFFF, red = 12'hF00. rgb is registered and aligned with active. rgb is 12'h000 whenever active=0.
- Not defined: the rgb port and its logic are absent. All other behaviour is unchanged.

Test Plan:
1. Reset 3 cycles, then enable=1 held -> first enabled cycle gives pos=(0,0), frame_start=1, active=1. Next frame_start occurs exactly 420000 cycles later.
2. Observe line 0 -> active high for x = 0..639; hsync low (SYNC_POL=0) for exactly 96 cycles starting at x=656; line_start pulses every 800 cycles.
3. Observe the full frame -> vsync low during lines 490 and 491 only, with edges coincident with pos_x=0. active stays 0 for lines 480..524.
4. fetch_req check -> high one cycle before every active pixel, including the (799,524)->(0,0) wrap. Count of fetch_req-high cycles equals count of active-high cycles (307200 per frame).
5. Drop enable for 10 cycles at (700,100) -> all outputs frozen, hsync still asserted. Resumes at (701,100) with no pixel skipped.
6. Assert reset at (300,200) together with enable=1 -> next cycle shows the reset values. First enabled cycle after release gives (0,0). With VIDEO_TIMING_TEST_PATTERN_EN: rgb=12'hFFF at x=0, 12'hF00 at x=400, 12'h000 at x=640.
